// File: rtl/alu_multicycle.sv
// alu_multicycle: handshaked ALU with single-cycle arithmetic/logic/shift/SLT
// operations and iterative (one bit per cycle) shift-add multiply and
// restoring divide producing full 2N-bit product / quotient+remainder.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  issue handshake; operands latched on acceptance
//   operation, sign      4-bit opcode, 1 = signed arithmetic
//   a, b                 N-bit operands
//   out_valid/out_ready  result handshake; results held until drained
//   result_lo            result / low product / quotient
//   result_hi            high product / remainder, 0 otherwise
//   zero, overflow, div_by_zero  flags registered with the result
module alu_multicycle #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   operation,
  input  logic         sign,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result_lo,
  output logic [N-1:0] result_hi,
  output logic         zero,
  output logic         overflow,
  output logic         div_by_zero
);

  localparam int unsigned SHW = $clog2(N);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SLL = 4'h7;
  localparam logic [3:0] OP_SRL = 4'h8;
  localparam logic [3:0] OP_SRA = 4'h9;
  localparam logic [3:0] OP_SLT = 4'hA;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  state_e         state_q;
  logic [N-1:0]   acc_q;      // MUL: high partial product, DIV: partial remainder
  logic [N-1:0]   aux_q;      // MUL: multiplier/low product, DIV: dividend/quotient
  logic [N-1:0]   opnd_q;     // MUL: multiplicand magnitude, DIV: divisor magnitude
  logic [SHW-1:0] cnt_q;
  logic           sign_q;
  logic           neg_lo_q;   // negate quotient / whole product at the end
  logic           neg_hi_q;   // negate remainder at the end
  logic           div_ovf_q;  // signed MIN / -1
  logic           out_valid_q;
  logic [N-1:0]   res_lo_q;
  logic [N-1:0]   res_hi_q;
  logic           zero_q;
  logic           ovf_q;
  logic           dbz_q;

  logic           accept;
  logic [SHW-1:0] shamt;
  logic [N:0]     sum_w;
  logic [N:0]     diff_w;
  logic           lt_w;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic           neg_prod;
  logic           b_is_zero;

  logic [N-1:0]   sc_lo_d;
  logic [N-1:0]   sc_hi_d;
  logic           sc_zero_d;
  logic           sc_ovf_d;
  logic           sc_dbz_d;

  logic [N:0]     mul_add;
  logic [N-1:0]   mul_acc_d;
  logic [N-1:0]   mul_aux_d;
  logic [2*N-1:0] mul_prod;
  logic [N-1:0]   mul_lo_d;
  logic [N-1:0]   mul_hi_d;
  logic           mul_ovf_d;

  logic [N:0]     div_shl;
  logic           div_ge;
  logic [N-1:0]   div_sub;
  logic [N-1:0]   div_acc_d;
  logic [N-1:0]   div_aux_d;
  logic [N-1:0]   div_lo_d;
  logic [N-1:0]   div_hi_d;

  logic           last_iter;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;

  assign shamt     = b[SHW-1:0];
  assign sum_w     = {1'b0, a} + {1'b0, b};
  assign diff_w    = {1'b0, a} - {1'b0, b};
  assign lt_w      = sign ? ($signed(a) < $signed(b)) : (a < b);
  assign a_mag     = (sign && a[N-1]) ? -a : a;
  assign b_mag     = (sign && b[N-1]) ? -b : b;
  assign neg_prod  = sign && (a[N-1] ^ b[N-1]);
  assign b_is_zero = (b == '0);
  assign last_iter = (cnt_q == SHW'(N - 1));

  // Single-cycle results, also covering DIV by zero.
  always_comb begin
    sc_lo_d  = '0;
    sc_hi_d  = '0;
    sc_ovf_d = 1'b0;
    sc_dbz_d = 1'b0;
    case (operation)
      OP_ADD: begin
        sc_lo_d  = sum_w[N-1:0];
        sc_ovf_d = sign ? ((a[N-1] == b[N-1]) && (sum_w[N-1] != a[N-1])) : sum_w[N];
      end
      OP_SUB: begin
        sc_lo_d  = diff_w[N-1:0];
        sc_ovf_d = sign ? ((a[N-1] != b[N-1]) && (diff_w[N-1] != a[N-1])) : diff_w[N];
      end
      OP_DIV: begin
        sc_lo_d  = '1;
        sc_hi_d  = a;
        sc_dbz_d = 1'b1;
      end
      OP_AND:  sc_lo_d = a & b;
      OP_OR:   sc_lo_d = a | b;
      OP_NOT:  sc_lo_d = ~a;
      OP_SLL:  sc_lo_d = a << shamt;
      OP_SRL:  sc_lo_d = a >> shamt;
      OP_SRA:  sc_lo_d = $signed(a) >>> shamt;
      OP_SLT:  sc_lo_d = {{(N-1){1'b0}}, lt_w};
      default: ;
    endcase
    // Undefined opcodes report every flag clear, including zero.
    sc_zero_d = (operation <= OP_SLT) && (sc_lo_d == '0);
  end

  // One shift-add multiply step and one restoring divide step per cycle;
  // the final step's outputs are sign-corrected and written to the result
  // registers directly so no extra cycle is spent on the fix-up.
  always_comb begin
    mul_add   = {1'b0, acc_q} + (aux_q[0] ? {1'b0, opnd_q} : '0);
    mul_acc_d = mul_add[N:1];
    mul_aux_d = {mul_add[0], aux_q[N-1:1]};
    mul_prod  = {mul_acc_d, mul_aux_d};
    if (neg_lo_q) begin
      mul_prod = -mul_prod;
    end
    mul_lo_d  = mul_prod[N-1:0];
    mul_hi_d  = mul_prod[2*N-1:N];
    mul_ovf_d = sign_q ? (mul_hi_d != {N{mul_lo_d[N-1]}}) : (mul_hi_d != '0);

    div_shl   = {acc_q, aux_q[N-1]};
    div_ge    = (div_shl >= {1'b0, opnd_q});
    div_sub   = div_shl[N-1:0] - opnd_q;
    div_acc_d = div_ge ? div_sub : div_shl[N-1:0];
    div_aux_d = {aux_q[N-2:0], div_ge};
    div_lo_d  = neg_lo_q ? -div_aux_d : div_aux_d;
    div_hi_d  = neg_hi_q ? -div_acc_d : div_acc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      aux_q       <= '0;
      opnd_q      <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      neg_lo_q    <= 1'b0;
      neg_hi_q    <= 1'b0;
      div_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      res_lo_q    <= '0;
      res_hi_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      sign_q <= sign;
      cnt_q  <= '0;
      if (operation == OP_MUL) begin
        state_q     <= S_MUL;
        out_valid_q <= 1'b0;
        acc_q       <= '0;
        aux_q       <= b_mag;
        opnd_q      <= a_mag;
        neg_lo_q    <= neg_prod;
      end else if ((operation == OP_DIV) && !b_is_zero) begin
        state_q     <= S_DIV;
        out_valid_q <= 1'b0;
        acc_q       <= '0;
        aux_q       <= a_mag;
        opnd_q      <= b_mag;
        neg_lo_q    <= neg_prod;
        neg_hi_q    <= sign && a[N-1];
        div_ovf_q   <= sign && (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
      end else begin
        state_q     <= S_DONE;
        out_valid_q <= 1'b1;
        res_lo_q    <= sc_lo_d;
        res_hi_q    <= sc_hi_d;
        zero_q      <= sc_zero_d;
        ovf_q       <= sc_ovf_d;
        dbz_q       <= sc_dbz_d;
      end
    end else begin
      case (state_q)
        S_MUL: begin
          acc_q <= mul_acc_d;
          aux_q <= mul_aux_d;
          cnt_q <= cnt_q + SHW'(1);
          if (last_iter) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            res_lo_q    <= mul_lo_d;
            res_hi_q    <= mul_hi_d;
            zero_q      <= (mul_lo_d == '0);
            ovf_q       <= mul_ovf_d;
            dbz_q       <= 1'b0;
          end
        end
        S_DIV: begin
          acc_q <= div_acc_d;
          aux_q <= div_aux_d;
          cnt_q <= cnt_q + SHW'(1);
          if (last_iter) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            res_lo_q    <= div_lo_d;
            res_hi_q    <= div_hi_d;
            zero_q      <= (div_lo_d == '0);
            ovf_q       <= div_ovf_q;
            dbz_q       <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign result_lo   = res_lo_q;
  assign result_hi   = res_hi_q;
  assign zero        = zero_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_multicycle.sv
`timescale 1ns/1ps
module tb_alu_multicycle;

  localparam int unsigned N = 8;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_SLL = 4'h7;
  localparam logic [3:0] OP_SRL = 4'h8;
  localparam logic [3:0] OP_SRA = 4'h9;
  localparam logic [3:0] OP_SLT = 4'hA;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   operation;
  logic         sign;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] result_lo;
  logic [N-1:0] result_hi;
  logic         zero;
  logic         overflow;
  logic         div_by_zero;

  alu_multicycle #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .operation   (operation),
    .sign        (sign),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .zero        (zero),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       z;
    logic       o;
    logic       d;
    int         lat;
  } res_t;

  typedef struct {
    logic [3:0] op;
    logic       sg;
    logic [7:0] a;
    logic [7:0] b;
    res_t       r;
  } vec_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model built on native integer arithmetic.
  function automatic res_t model(input logic [3:0] op, input logic sg,
                                 input logic [7:0] aa, input logic [7:0] bb);
    res_t       e;
    int         sa;
    int         sbv;
    int         r;
    int         q;
    logic [2:0] sh;
    e.lo = '0; e.hi = '0; e.z = 1'b0; e.o = 1'b0; e.d = 1'b0; e.lat = 1;
    sa  = sg ? int'($signed(aa)) : int'(aa);
    sbv = sg ? int'($signed(bb)) : int'(bb);
    sh  = bb[2:0];
    case (op)
      OP_ADD: begin r = sa + sbv; e.lo = r[7:0]; e.o = sg ? (r > 127 || r < -128) : (r > 255); end
      OP_SUB: begin r = sa - sbv; e.lo = r[7:0]; e.o = sg ? (r > 127 || r < -128) : (r < 0); end
      OP_MUL: begin
        r = sa * sbv; e.lo = r[7:0]; e.hi = r[15:8]; e.lat = 9;
        e.o = sg ? (r > 127 || r < -128) : (r > 255);
      end
      OP_DIV: begin
        if (bb == 8'h00) begin
          e.lo = 8'hFF; e.hi = aa; e.d = 1'b1;
        end else begin
          q = sa / sbv; r = sa % sbv;
          e.lo = q[7:0]; e.hi = r[7:0]; e.lat = 9;
          e.o = sg && (sa == -128) && (sbv == -1);
        end
      end
      OP_AND: e.lo = aa & bb;
      OP_OR:  e.lo = aa | bb;
      OP_NOT: e.lo = ~aa;
      OP_SLL: e.lo = aa << sh;
      OP_SRL: e.lo = aa >> sh;
      OP_SRA: begin r = int'($signed(aa)) >>> sh; e.lo = r[7:0]; end
      OP_SLT: e.lo = (sa < sbv) ? 8'd1 : 8'd0;
      default: ;
    endcase
    e.z = (op <= OP_SLT) && (e.lo == 8'h00);
    return e;
  endfunction

  // Issue one op, wait (bounded) for its result, sample it, then drain it.
  task automatic run_vec(input logic [3:0] op, input logic sg, input logic [7:0] aa,
                         input logic [7:0] bb, output res_t obs);
    int guard;
    operation = op; sign = sg; a = aa; b = bb; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    obs.lat = 1;
    while (!out_valid && obs.lat < 40) begin
      @(posedge clk); #1;
      obs.lat++;
    end
    obs.lo = result_lo; obs.hi = result_hi; obs.z = zero; obs.o = overflow; obs.d = div_by_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    res_t obs;
    bit   seen;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    n_checks++;
    if ({out_valid, in_ready, result_lo, result_hi, zero, overflow, div_by_zero} !== {1'b0, 1'b1, 8'h00, 8'h00, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b ir=%b lo=%h hi=%h z=%b o=%b d=%b, want ov=0 ir=1 lo=00 hi=00 flags=000",
               out_valid, in_ready, result_lo, result_hi, zero, overflow, div_by_zero);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    // Leave a nonzero result behind, then abort a multiply with reset.
    run_vec(OP_ADD, 1'b0, 8'h11, 8'h22, obs);
    operation = OP_MUL; sign = 1'b0; a = 8'h12; b = 8'h34; in_valid = 1'b1;
    sb.push_back(model(OP_MUL, 1'b0, 8'h12, 8'h34));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    sb.delete();
    n_checks++;
    if ({out_valid, in_ready, result_lo} !== {1'b0, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_mid_mul: got ov=%b ir=%b lo=%h, want ov=0 ir=1 lo=00", out_valid, in_ready, result_lo);
    end
    rst = 1'b0;
    seen = 1'b0;
    for (int unsigned i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_stale: got out_valid seen=%b, want 0", seen);
    end
  endtask

  task automatic test_addsub();
    vec_t v[5] = '{
      '{OP_ADD, 1'b1, 8'h7F, 8'h01, '{8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1}},
      '{OP_SUB, 1'b0, 8'h33, 8'h33, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1}},
      '{OP_ADD, 1'b0, 8'hFF, 8'h01, '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1}},
      '{OP_SUB, 1'b0, 8'h01, 8'h02, '{8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1}},
      '{OP_SUB, 1'b1, 8'h80, 8'h01, '{8'h7F, 8'h00, 1'b0, 1'b1, 1'b0, 1}}
    };
    res_t obs;
    res_t e;
    for (int unsigned i = 0; i < 5; i++) begin
      sb.push_back(v[i].r);
      run_vec(v[i].op, v[i].sg, v[i].a, v[i].b, obs);
      e = sb.pop_front();
      n_checks++;
      if ({obs.lo, obs.hi, obs.z, obs.o, obs.d} !== {e.lo, e.hi, e.z, e.o, e.d}) begin
        n_fail++;
        $display("FAIL addsub[%0d] result: got lo=%h hi=%h z=%b o=%b d=%b, want lo=%h hi=%h z=%b o=%b d=%b",
                 i, obs.lo, obs.hi, obs.z, obs.o, obs.d, e.lo, e.hi, e.z, e.o, e.d);
      end
      n_checks++;
      if (obs.lat !== e.lat) begin
        n_fail++;
        $display("FAIL addsub[%0d] latency: got %0d, want %0d", i, obs.lat, e.lat);
      end
    end
  endtask

  task automatic test_mul();
    vec_t v[5] = '{
      '{OP_MUL, 1'b1, 8'hFD, 8'h05, '{8'hF1, 8'hFF, 1'b0, 1'b0, 1'b0, 9}},
      '{OP_MUL, 1'b0, 8'h10, 8'h10, '{8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 9}},
      '{OP_MUL, 1'b1, 8'h80, 8'h80, '{8'h00, 8'h40, 1'b1, 1'b1, 1'b0, 9}},
      '{OP_MUL, 1'b0, 8'hFF, 8'hFF, '{8'h01, 8'hFE, 1'b0, 1'b1, 1'b0, 9}},
      '{OP_MUL, 1'b1, 8'hFF, 8'h01, '{8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, 9}}
    };
    res_t obs;
    res_t e;
    for (int unsigned i = 0; i < 5; i++) begin
      sb.push_back(v[i].r);
      run_vec(v[i].op, v[i].sg, v[i].a, v[i].b, obs);
      e = sb.pop_front();
      n_checks++;
      if ({obs.lo, obs.hi, obs.z, obs.o, obs.d} !== {e.lo, e.hi, e.z, e.o, e.d}) begin
        n_fail++;
        $display("FAIL mul[%0d] result: got lo=%h hi=%h z=%b o=%b d=%b, want lo=%h hi=%h z=%b o=%b d=%b",
                 i, obs.lo, obs.hi, obs.z, obs.o, obs.d, e.lo, e.hi, e.z, e.o, e.d);
      end
      n_checks++;
      if (obs.lat !== e.lat) begin
        n_fail++;
        $display("FAIL mul[%0d] latency: got %0d, want %0d", i, obs.lat, e.lat);
      end
    end
  endtask

  task automatic test_div();
    vec_t v[5] = '{
      '{OP_DIV, 1'b1, 8'hF9, 8'h02, '{8'hFD, 8'hFF, 1'b0, 1'b0, 1'b0, 9}},
      '{OP_DIV, 1'b0, 8'h2A, 8'h00, '{8'hFF, 8'h2A, 1'b0, 1'b0, 1'b1, 1}},
      '{OP_DIV, 1'b1, 8'h80, 8'hFF, '{8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 9}},
      '{OP_DIV, 1'b0, 8'hC8, 8'h07, '{8'h1C, 8'h04, 1'b0, 1'b0, 1'b0, 9}},
      '{OP_DIV, 1'b1, 8'h07, 8'hFE, '{8'hFD, 8'h01, 1'b0, 1'b0, 1'b0, 9}}
    };
    res_t obs;
    res_t e;
    for (int unsigned i = 0; i < 5; i++) begin
      sb.push_back(v[i].r);
      run_vec(v[i].op, v[i].sg, v[i].a, v[i].b, obs);
      e = sb.pop_front();
      n_checks++;
      if ({obs.lo, obs.hi, obs.z, obs.o, obs.d} !== {e.lo, e.hi, e.z, e.o, e.d}) begin
        n_fail++;
        $display("FAIL div[%0d] result: got lo=%h hi=%h z=%b o=%b d=%b, want lo=%h hi=%h z=%b o=%b d=%b",
                 i, obs.lo, obs.hi, obs.z, obs.o, obs.d, e.lo, e.hi, e.z, e.o, e.d);
      end
      n_checks++;
      if (obs.lat !== e.lat) begin
        n_fail++;
        $display("FAIL div[%0d] latency: got %0d, want %0d", i, obs.lat, e.lat);
      end
    end
  endtask

  task automatic test_logic_shift_slt();
    vec_t v[7] = '{
      '{OP_SLT, 1'b0, 8'hFF, 8'h01, '{8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1}},
      '{OP_SLT, 1'b1, 8'hFF, 8'h01, '{8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1}},
      '{OP_SLL, 1'b0, 8'h81, 8'h09, '{8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1}},
      '{OP_SRL, 1'b1, 8'h90, 8'h04, '{8'h09, 8'h00, 1'b0, 1'b0, 1'b0, 1}},
      '{OP_NOT, 1'b0, 8'h0F, 8'h55, '{8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1}},
      '{OP_OR,  1'b0, 8'hA0, 8'h05, '{8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 1}},
      '{4'hF,   1'b1, 8'h12, 8'h34, '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1}}
    };
    res_t obs;
    res_t e;
    for (int unsigned i = 0; i < 7; i++) begin
      sb.push_back(v[i].r);
      run_vec(v[i].op, v[i].sg, v[i].a, v[i].b, obs);
      e = sb.pop_front();
      n_checks++;
      if ({obs.lo, obs.hi, obs.z, obs.o, obs.d, obs.lat} !== {e.lo, e.hi, e.z, e.o, e.d, e.lat}) begin
        n_fail++;
        $display("FAIL misc[%0d]: got lo=%h hi=%h z=%b o=%b d=%b lat=%0d, want lo=%h hi=%h z=%b o=%b d=%b lat=%0d",
                 i, obs.lo, obs.hi, obs.z, obs.o, obs.d, obs.lat, e.lo, e.hi, e.z, e.o, e.d, e.lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t e;
    int   guard;
    sb.push_back('{8'hE4, 8'h00, 1'b0, 1'b0, 1'b0, 1});
    operation = OP_SRA; sign = 1'b1; a = 8'h90; b = 8'h02; in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = sb.pop_front();
    for (int unsigned i = 0; i < 5; i++) begin
      n_checks++;
      if ({out_valid, in_ready, result_lo} !== {1'b1, 1'b0, e.lo}) begin
        n_fail++;
        $display("FAIL backpressure[%0d]: got ov=%b ir=%b lo=%h, want ov=1 ir=0 lo=%h", i, out_valid, in_ready, result_lo, e.lo);
      end
      @(posedge clk); #1;
    end
    operation = OP_AND; sign = 1'b0; a = 8'hF0; b = 8'h3C; in_valid = 1'b1; out_ready = 1'b1;
    sb.push_back(model(OP_AND, 1'b0, 8'hF0, 8'h3C));
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL same_edge_ready: got in_ready=%b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if ({out_valid, result_lo, result_hi, zero} !== {1'b1, e.lo, e.hi, e.z}) begin
      n_fail++;
      $display("FAIL back_to_back: got ov=%b lo=%h hi=%h z=%b, want ov=1 lo=%h hi=%h z=%b",
               out_valid, result_lo, result_hi, zero, e.lo, e.hi, e.z);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL drain_idle: got ov=%b ir=%b, want ov=0 ir=1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    res_t       obs;
    res_t       e;
    logic [3:0] op;
    logic       sg;
    logic [7:0] ra;
    logic [7:0] rb;
    for (int unsigned i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 11));
      sg = 1'($urandom_range(0, 1));
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      sb.push_back(model(op, sg, ra, rb));
      run_vec(op, sg, ra, rb, obs);
      e = sb.pop_front();
      n_checks++;
      if ({obs.lo, obs.hi, obs.z, obs.o, obs.d, obs.lat} !== {e.lo, e.hi, e.z, e.o, e.d, e.lat}) begin
        n_fail++;
        $display("FAIL random[%0d] op=%h s=%b a=%h b=%h: got lo=%h hi=%h z=%b o=%b d=%b lat=%0d, want lo=%h hi=%h z=%b o=%b d=%b lat=%0d",
                 i, op, sg, ra, rb, obs.lo, obs.hi, obs.z, obs.o, obs.d, obs.lat, e.lo, e.hi, e.z, e.o, e.d, e.lat);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    operation = '0; sign = 1'b0; a = '0; b = '0;
    test_reset();
    test_addsub();
    test_mul();
    test_div();
    test_logic_shift_slt();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised, handshaked successor to the combinational CPU ALU.
- Single-cycle ops: add, sub, logic, shifts, set-less-than.
- Iterative ops: multiply by shift-add and divide by restoring division, each in N iterations, with full 2N-bit product and remainder outputs.
- Sits between the decode/issue stage and writeback. The issue side stalls on in_ready; writeback drains via out_ready.

Parameters:
- N, 32, operand/result width (≥4, power of two).
- SHW, $clog2(N), shift-amount width (derived localparam, not overridable).

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- in_valid  in  1  operation request
- in_ready  out  1  ALU can accept a request this cycle
- operation  in  4  opcode (see Behaviour)
- sign  in  1  1 = signed arithmetic, 0 = unsigned
- a  in  N  operand A
- b  in  N  operand B
- out_valid  out  1  result registers hold a valid result
- out_ready  in  1  consumer accepts result
- result_lo  out  N  primary result / low product / quotient
- result_hi  out  N  high product / remainder; 0 for other ops
- zero  out  1  result_lo == 0
- overflow  out  1  signed add/sub overflow, or MUL high half not a sign/zero extension of low half
- div_by_zero  out  1  DIV issued with b == 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset: all outputs 0 except in_ready=1. State=IDLE. Reset mid-operation aborts the operation; no result is produced.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 MUL, 0011 DIV, 0100 AND, 0101 OR
  - 0110 NOT a, 0111 SLL, 1000 SRL, 1001 SRA, 1010 SLT (result_lo = a<b ? 1 : 0 per sign)
  - Others give result 0 with all flags 0.
- Shifts use b[SHW-1:0] only. SRA ignores sign.
- Handshake:
  - Accept occurs when in_valid && in_ready at a clk edge; operands and opcode are latched.
  - in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back issue is allowed when the result drains in the same cycle.
  - out_valid holds, and result/flags stay stable, until out_ready is sampled high.
- FSM: IDLE, MUL, DIV, DONE.
  - IDLE --accept single-cycle op--> DONE (out_valid high the next cycle; latency 1).
  - IDLE --accept MUL--> MUL. Iterate N cycles, then DONE. out_valid asserts N+1 cycles after accept.
  - IDLE --accept DIV, b!=0--> DIV. Iterate N cycles, then DONE (latency N+1).
  - DIV with b==0 --> DONE directly (latency 1): result_lo = all ones, result_hi = a, div_by_zero = 1.
  - DONE & out_ready & !accept --> IDLE. DONE & out_ready & accept --> next state per the new op.
- Signed MUL/DIV: operate on magnitudes, then fix the sign. Quotient truncates toward zero; remainder takes the dividend's sign.
- Signed DIV of MIN by -1: quotient = MIN, remainder = 0, overflow = 1.
- Unsigned MUL: overflow = (result_hi != 0). Unsigned ADD/SUB: overflow = carry-out / borrow.
- Flags register together with results. zero reflects result_lo only.
- Inputs are ignored while busy (in_ready=0). No combinational path from in_valid to out_valid.

Test Plan (N=8):
- Reset held 2 cycles mid-MUL -> out_valid=0, in_ready=1, result_lo=0; no stale result after release.
- ADD sign=1 a=0x7F b=0x01 -> one cycle later result_lo=0x80, overflow=1, zero=0. SUB a=b=0x33 -> result_lo=0, zero=1.
- MUL sign=1 a=0xFD(-3) b=0x05 -> out_valid exactly 9 cycles after accept, {hi,lo}=0xFFF1, overflow=0. Unsigned 0x10*0x10 -> hi=0x01, lo=0x00, overflow=1.
- DIV sign=1 a=0xF9(-7) b=0x02 -> lo=0xFD(-3), hi=0xFF(-1), latency 9. DIV b=0 a=0x2A -> latency 1, lo=0xFF, hi=0x2A, div_by_zero=1.
- Backpressure: out_ready=0 for 5 cycles after SRA a=0x90 b=0x02 -> lo=0xE4 held stable, in_ready=0. Then out_ready=1 with in_valid AND a=0xF0 b=0x3C -> same-edge accept; 0x30 valid next cycle.
- Signed DIV 0x80 / 0xFF -> lo=0x80, hi=0x00, overflow=1. SLT sign=0 a=0xFF b=0x01 -> 0; sign=1 -> 1.
